// File: rtl/w_order_sched.sv
// w_order_sched: W-channel write-data scheduler for an AXI interconnect.
// The AW arbiter pushes {master id, AWLEN} into a small order queue for each
// granted burst. W beats are then forwarded from the per-master W FIFOs in
// exactly that order, one whole burst at a time, so beats from different
// masters never interleave.
//
// Optional feature: define W_SCHED_LEN_CHECK_EN to count beats against the
// granted AWLEN. The burst then ends on the beat count rather than on WLAST,
// and a mismatch between WLAST and the count sets a sticky len_err.
// Without the macro, aw_grant_len is ignored, the burst ends on WLAST and
// len_err is tied low.
module w_order_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = 4,
    parameter int NUM_MASTERS = 2,
    parameter int ORDER_DEPTH = 4,
    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic                              aw_grant_valid,
    input  logic [IDW-1:0]                    aw_grant_id,
    input  logic [7:0]                        aw_grant_len,
    output logic                              order_full,
    input  logic [NUM_MASTERS-1:0]            fifo_empty,
    output logic [NUM_MASTERS-1:0]            fifo_pop,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] fifo_WDATA,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] fifo_WSTRB,
    input  logic [NUM_MASTERS-1:0]            fifo_WLAST,
    output logic [DATA_WIDTH-1:0]             WDATA,
    output logic [STRB_WIDTH-1:0]             WSTRB,
    output logic                              WLAST,
    output logic                              WVALID,
    input  logic                              WREADY,
    output logic                              busy,
    output logic                              len_err
);

    localparam int PW = $clog2(ORDER_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Order queue storage and bookkeeping
    logic [IDW-1:0] idMem_q [ORDER_DEPTH];
    logic [PW-1:0]  wrPtr_q;
    logic [PW-1:0]  rdPtr_q;
    logic [CW-1:0]  count_q;

    // Burst currently being forwarded
    logic [IDW-1:0] curId_q, curId_d;

`ifdef W_SCHED_LEN_CHECK_EN
    logic [7:0] lenMem_q [ORDER_DEPTH];
    logic [7:0] curLen_q, curLen_d;
    logic [7:0] beat_q, beat_d;
    logic       lenErr_q, lenErr_d;
`else
    logic       unusedLen;
`endif

    logic                  qEmpty;
    logic                  push;
    logic                  pop;
    logic                  xfer;
    logic                  burstEnd;
    logic                  selEmpty;
    logic [DATA_WIDTH-1:0] selData;
    logic [STRB_WIDTH-1:0] selStrb;
    logic                  selLast;

    assign order_full = (count_q == CW'(ORDER_DEPTH));
    assign qEmpty     = (count_q == '0);
    assign push       = aw_grant_valid && !order_full;
    assign busy       = (state_q == BURST);

`ifdef W_SCHED_LEN_CHECK_EN
    assign len_err = lenErr_q;
`else
    assign len_err   = 1'b0;
    assign unusedLen = ^aw_grant_len;
`endif

    // Select the FIFO front of the master owning the current burst
    always_comb begin
        selEmpty = 1'b1;
        selData  = '0;
        selStrb  = '0;
        selLast  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (curId_q == IDW'(i)) begin
                selEmpty = fifo_empty[i];
                selData  = fifo_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                selStrb  = fifo_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
                selLast  = fifo_WLAST[i];
            end
        end
    end

    // FSM next state, burst loading from the queue head, and W outputs
    always_comb begin
        state_d  = state_q;
        curId_d  = curId_q;
        pop      = 1'b0;
        xfer     = 1'b0;
        burstEnd = 1'b0;
        WVALID   = 1'b0;
        WDATA    = '0;
        WSTRB    = '0;
        WLAST    = 1'b0;
        fifo_pop = '0;
`ifdef W_SCHED_LEN_CHECK_EN
        curLen_d = curLen_q;
        beat_d   = beat_q;
        lenErr_d = lenErr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!qEmpty) begin
                    pop     = 1'b1;
                    curId_d = idMem_q[rdPtr_q];
                    state_d = BURST;
`ifdef W_SCHED_LEN_CHECK_EN
                    curLen_d = lenMem_q[rdPtr_q];
                    beat_d   = '0;
`endif
                end
            end
            BURST: begin
                WVALID = !selEmpty;
                WDATA  = selData;
                WSTRB  = selStrb;
                WLAST  = selLast;
                xfer   = !selEmpty && WREADY;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    fifo_pop[i] = xfer && (curId_q == IDW'(i));
                end
`ifdef W_SCHED_LEN_CHECK_EN
                burstEnd = xfer && (beat_q == curLen_q);
                if (xfer) begin
                    beat_d = beat_q + 8'd1;
                    if ((selLast && (beat_q < curLen_q)) ||
                        (!selLast && (beat_q == curLen_q))) begin
                        lenErr_d = 1'b1;
                    end
                end
`else
                burstEnd = xfer && selLast;
`endif
                if (burstEnd) begin
                    if (!qEmpty) begin
                        pop     = 1'b1;
                        curId_d = idMem_q[rdPtr_q];
`ifdef W_SCHED_LEN_CHECK_EN
                        curLen_d = lenMem_q[rdPtr_q];
                        beat_d   = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Order queue entry storage; contents are don't-care until pushed
    always_ff @(posedge ACLK) begin
        if (push) begin
            idMem_q[wrPtr_q] <= aw_grant_id;
`ifdef W_SCHED_LEN_CHECK_EN
            lenMem_q[wrPtr_q] <= aw_grant_len;
`endif
        end
    end

    // Order queue pointers and occupancy; pointers wrap naturally at ORDER_DEPTH
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state and current burst registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            curId_q <= '0;
`ifdef W_SCHED_LEN_CHECK_EN
            curLen_q <= '0;
            beat_q   <= '0;
            lenErr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            curId_q <= curId_d;
`ifdef W_SCHED_LEN_CHECK_EN
            curLen_q <= curLen_d;
            beat_q   <= beat_d;
            lenErr_q <= lenErr_d;
`endif
        end
    end

endmodule
